md_wb_queue: RTL and testbench
==============================

MD_WB_QUEUE -- requirements
Module: md_wb_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of buffered multiply/divide results; power of two, at least 2.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port md_valid  input  1  mult/div result offered.
REQ-005 The block SHALL have port md_ready  output  1  queue can accept a result.
REQ-006 The block SHALL have port md_waddr  input  5  destination register of the offered result.
REQ-007 The block SHALL have port md_wdata  input  32  offered result value.
REQ-008 The block SHALL have port main_we  input  1  the main pipeline is writing the register file this cycle.
REQ-009 The block SHALL have port we_mult_div  output  1  secondary register-file write enable.
REQ-010 The block SHALL have port waddr_mult_div  output  5  secondary write address.
REQ-011 The block SHALL have port wdata_mult_div  output  32  secondary write data.
REQ-012 The block SHALL have port count  output  $clog2(DEPTH+1)  number of queued entries.
REQ-013 The block SHALL have port busy  output  32  per-register pending-write mask; present only under MD_WB_SCOREBOARD_EN.

Function
REQ-014 The block SHALL accept a result on any rising edge where md_valid and md_ready are both 1, and md_ready SHALL equal (count != DEPTH) and rst low.
REQ-015 The block SHALL take an accepted result with md_waddr == 0 as consumed and SHALL discard it without enqueuing it.
REQ-016 The block SHALL drain entries in strict acceptance order (FIFO).
REQ-017 The block SHALL drive we_mult_div = (count != 0) and not main_we, combinationally from main_we, so the main write port always wins.
REQ-018 The block SHALL drive waddr_mult_div/wdata_mult_div from the head entry whenever count != 0, and drive zero when empty.
REQ-019 The block SHALL pop the head entry on every edge where we_mult_div is 1.
REQ-020 The block SHALL make an accepted entry first visible at the head on the cycle after acceptance (minimum latency 1, no input-to-output bypass).
REQ-021 The block SHALL push and pop in the same cycle when both occur, leaving count unchanged.
REQ-022 The block SHALL wrap the read and write pointers modulo DEPTH with no loss or duplication of entries.
REQ-023 The block SHALL hold the head entry indefinitely while main_we stays 1, with no timeout and no drop.

Reset
REQ-024 The block SHALL, on rst assertion and regardless of clk, clear pointers and count, empty the queue and drive md_ready=0, we_mult_div=0, waddr_mult_div=0, wdata_mult_div=0, busy=0.
REQ-025 The block SHALL discard any queued or in-flight entries when reset is asserted mid-operation, and SHALL raise md_ready on the first cycle after rst deasserts.

Configuration
REQ-026 The block SHALL, with MD_WB_SCOREBOARD_EN defined, drive busy[r]=1 exactly while at least one queued entry targets register r, with busy[0] always 0, so decode stalls on RAW and WAW against queued results.
REQ-027 The block SHALL, without MD_WB_SCOREBOARD_EN, omit the busy port and all scoreboard logic and leave every other behaviour unchanged.

Structure
REQ-028 The block SHALL take XLEN=32 and REG_ADDR_W=5 from the shared package cpu_pkg.
REQ-029 The block SHALL implement the storage as sub-module md_wb_fifo (generic synchronous FIFO, asynchronous reset), and keep the x0 filter, priority gating and scoreboard in md_wb_queue.

Verification
REQ-030 The bench SHALL push (r5, 0x12345678) with main_we=0 and check we_mult_div=1, waddr=5, wdata=0x12345678 on the next cycle, then count=0.
REQ-031 The bench SHALL push r7 while main_we=1 for 3 cycles and check we_mult_div=0 during those cycles and the write issued on the first cycle main_we=0.
REQ-032 The bench SHALL hold main_we=1 and push 4 results (DEPTH=4), then check count=4 and md_ready=0, that a 5th offer is not accepted, and that the drain order is r1, r2, r3, r4.
REQ-033 The bench SHALL push (r0, 0xDEADBEEF) and check that count stays 0 and we_mult_div never asserts.
REQ-034 The bench SHALL keep the queue half full under continuous push/pop for 20 cycles and check that count is constant and the data matches a reference model across pointer wrap.
REQ-035 The bench SHALL assert rst asynchronously with 3 entries queued and check that all outputs are 0 immediately, and that md_ready=1 and busy=0 after release (busy only with MD_WB_SCOREBOARD_EN).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the multiply/divide write-back payload.
package cpu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [XLEN-1:0]       wdata;
    } md_wb_entry_t;

endpackage

// File: rtl/md_wb_fifo.sv
// Generic synchronous FIFO with asynchronous reset; head is read combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module md_wb_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: it is only observed while count != 0.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/md_wb_queue.sv
// Buffers multiply/divide results and writes them back through the secondary
// register-file port whenever the main pipeline leaves it idle.
// Optional per-register pending mask: define MD_WB_SCOREBOARD_EN.
module md_wb_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         md_valid,
    output logic                         md_ready,
    input  logic [REG_ADDR_W-1:0]        md_waddr,
    input  logic [XLEN-1:0]              md_wdata,
    input  logic                         main_we,
    output logic                         we_mult_div,
    output logic [REG_ADDR_W-1:0]        waddr_mult_div,
    output logic [XLEN-1:0]              wdata_mult_div,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef MD_WB_SCOREBOARD_EN
    ,
    output logic [NUM_REGS-1:0]          busy
`endif
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    md_wb_entry_t in_entry;
    md_wb_entry_t head;
    logic         push;
    logic         pop;
    logic         empty;

    // Writes to x0 are architecturally void, so they are accepted and dropped.
    assign md_ready = !rst && (count != CW'(DEPTH));
    assign push     = md_valid && md_ready && (md_waddr != '0);
    assign in_entry = '{waddr: md_waddr, wdata: md_wdata};

    md_wb_fifo #(
        .WIDTH ($bits(md_wb_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_entry),
        .rdata (head),
        .count (count)
    );

    // The main pipeline owns the register-file port whenever it writes.
    assign empty          = (count == '0);
    assign we_mult_div    = !empty && !main_we;
    assign pop            = we_mult_div;
    assign waddr_mult_div = empty ? '0 : head.waddr;
    assign wdata_mult_div = empty ? '0 : head.wdata;

`ifdef MD_WB_SCOREBOARD_EN
    assign busy[0] = 1'b0;

    // One occupancy counter per register; busy while any queued entry targets it.
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
        logic [CW-1:0] pend;
        logic          inc;
        logic          dec;

        assign inc = push && (md_waddr == REG_ADDR_W'(r));
        assign dec = pop && (head.waddr == REG_ADDR_W'(r));

        always_ff @(posedge clk or posedge rst) begin
            if (rst)               pend <= '0;
            else if (inc && !dec)  pend <= pend + CW'(1);
            else if (dec && !inc)  pend <= pend - CW'(1);
        end

        assign busy[r] = (pend != '0);
    end
`endif

endmodule

// File: tb/tb_md_wb_queue.sv
// Randomized and directed bench for md_wb_queue against a queue-based model.
// Honours MD_WB_SCOREBOARD_EN when the design is built with it.
module tb_md_wb_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          md_valid;
    logic          md_ready;
    logic [4:0]    md_waddr;
    logic [31:0]   md_wdata;
    logic          main_we;
    logic          we_mult_div;
    logic [4:0]    waddr_mult_div;
    logic [31:0]   wdata_mult_div;
    logic [CW-1:0] count;
`ifdef MD_WB_SCOREBOARD_EN
    logic [31:0]   busy;
`endif

    md_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .md_valid       (md_valid),
        .md_ready       (md_ready),
        .md_waddr       (md_waddr),
        .md_wdata       (md_wdata),
        .main_we        (main_we),
        .we_mult_div    (we_mult_div),
        .waddr_mult_div (waddr_mult_div),
        .wdata_mult_div (wdata_mult_div),
        .count          (count)
`ifdef MD_WB_SCOREBOARD_EN
        ,
        .busy           (busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        foreach (q[i]) b[q[i].a] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    // Compare every output against the model, then advance the model by one edge.
    task automatic tick();
        int  n;
        bit  acc;
        @(negedge clk);
        n = q.size();
        check("count",    64'(count),          64'(n));
        check("md_ready", 64'(md_ready),       64'(n != DEPTH));
        check("we",       64'(we_mult_div),    64'(n != 0 && !main_we));
        check("waddr",    64'(waddr_mult_div), (n != 0) ? 64'(q[0].a) : 64'd0);
        check("wdata",    64'(wdata_mult_div), (n != 0) ? 64'(q[0].d) : 64'd0);
`ifdef MD_WB_SCOREBOARD_EN
        check("busy",     64'(busy),           64'(model_busy()));
`endif
        acc = md_valid && (n != DEPTH);
        if (n != 0 && !main_we) void'(q.pop_front());
        if (acc && md_waddr != 5'd0) q.push_back('{md_waddr, md_wdata});
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"}, 64'(count),          64'd0);
        check({tag, "_ready"}, 64'(md_ready),       64'd0);
        check({tag, "_we"},    64'(we_mult_div),    64'd0);
        check({tag, "_waddr"}, 64'(waddr_mult_div), 64'd0);
        check({tag, "_wdata"}, 64'(wdata_mult_div), 64'd0);
`ifdef MD_WB_SCOREBOARD_EN
        check({tag, "_busy"},  64'(busy),           64'd0);
`endif
    endtask

    task automatic offer(input logic v, input logic [4:0] a, input logic [31:0] d, input logic mw);
        md_valid = v;
        md_waddr = a;
        md_wdata = d;
        main_we  = mw;
    endtask

    initial begin
        rst = 1'b1;
        offer(1'b0, 5'd0, 32'd0, 1'b0);
        #3;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("ready_after_reset", 64'(md_ready), 64'd1);

        // Single result written back the cycle after acceptance.
        offer(1'b1, 5'd5, 32'h12345678, 1'b0);
        tick();
        offer(1'b0, 5'd0, 32'd0, 1'b0);
        #1;
        check("single_we",    64'(we_mult_div),    64'd1);
        check("single_waddr", 64'(waddr_mult_div), 64'd5);
        check("single_wdata", 64'(wdata_mult_div), 64'h12345678);
        tick();
        check("single_drained", 64'(count), 64'd0);

        // Main pipeline holds the port for three cycles.
        offer(1'b1, 5'd7, 32'hA5A5_0007, 1'b1);
        tick();
        offer(1'b0, 5'd0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1 check("blocked_we", 64'(we_mult_div), 64'd0);
            tick();
        end
        main_we = 1'b0;
        #1;
        check("unblocked_we",    64'(we_mult_div),    64'd1);
        check("unblocked_waddr", 64'(waddr_mult_div), 64'd7);
        tick();

        // Fill to capacity, reject a fifth offer, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            offer(1'b1, 5'(i), 32'h1000_0000 + 32'(i), 1'b1);
            tick();
        end
        offer(1'b1, 5'd9, 32'hBAD0_0009, 1'b1);
        #1;
        check("full_count", 64'(count),    64'd4);
        check("full_ready", 64'(md_ready), 64'd0);
        tick();
        check("full_count_after_5th", 64'(count), 64'd4);
        offer(1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("drain_waddr", 64'(waddr_mult_div), 64'(i));
            check("drain_wdata", 64'(wdata_mult_div), 64'h1000_0000 + 64'(i));
            tick();
        end

        // Writes to x0 are swallowed.
        offer(1'b1, 5'd0, 32'hDEADBEEF, 1'b0);
        tick();
        offer(1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("x0_count", 64'(count),       64'd0);
            check("x0_we",    64'(we_mult_div), 64'd0);
            tick();
        end

        // Half full with simultaneous push/pop across pointer wrap.
        for (int i = 0; i < 2; i++) begin
            offer(1'b1, 5'(10 + i), $urandom, 1'b1);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            offer(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0);
            #1 check("steady_count", 64'(count), 64'd2);
            tick();
        end
        offer(1'b0, 5'd0, 32'd0, 1'b0);
        while (q.size() != 0) tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            offer(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 2) == 0));
            tick();
        end

        // Asynchronous reset with three entries queued.
        offer(1'b0, 5'd0, 32'd0, 1'b1);
        while (q.size() != 0) begin
            main_we = 1'b0;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 5'(20 + i), $urandom, 1'b1);
            tick();
        end
        offer(1'b0, 5'd0, 32'd0, 1'b0);
        #1 check("pre_reset_count", 64'(count), 64'd3);
        #1 rst = 1'b1;
        #1 check_all_zero("async_reset");
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("release_ready", 64'(md_ready), 64'd1);
`ifdef MD_WB_SCOREBOARD_EN
        check("release_busy",  64'(busy),     64'd0);
`endif
        for (int i = 0; i < 5; i++) tick();
        offer(1'b1, 5'd3, 32'hCAFE_0003, 1'b0);
        tick();
        offer(1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
